// File: rtl/sync_fifo_param.sv
// Synchronous single-clock FIFO with registered read data and count-decoded flags.
// Define SYNC_FIFO_ERR_EN to add the sticky ovf/udf error flags.
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    input  logic             rd,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
`ifdef SYNC_FIFO_ERR_EN
    output logic             ovf,
    output logic             udf,
`endif
    output logic [AW:0]      count
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_CNT    = (AW+1)'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             wr_ok, rd_ok;

    // Acceptance comes from the registered flags, so at full a simultaneous
    // write is dropped and at empty a simultaneous read is dropped.
    assign wr_ok = we && !full;
    assign rd_ok = rd && !empty;

    assign empty        = (count == '0);
    assign full         = (count == DEPTH_CNT);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    // Storage is never reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok)
            mem[wr_ptr] <= d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            q_valid <= rd_ok;
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) begin
                q      <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (we && full)
                ovf <= 1'b1;
            if (rd && empty)
                udf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboarded bench for sync_fifo_param (WIDTH=8, DEPTH=8, default thresholds).
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst, we, rd;
    logic [7:0] d, q;
    logic       q_valid, full, empty, almost_full, almost_empty;
    logic [3:0] count;
`ifdef SYNC_FIFO_ERR_EN
    logic       ovf, udf;
`endif

    sync_fifo_param dut (
        .clk(clk), .rst(rst), .we(we), .d(d), .rd(rd), .q(q), .q_valid(q_valid),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
`ifdef SYNC_FIFO_ERR_EN
        .ovf(ovf), .udf(udf),
`endif
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   errs = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: drive, take the edge, and if a read is expected to be accepted,
    // queue the word due on q in the cycle following this edge.
    task automatic step(input logic w, input logic [7:0] dv, input logic r,
                        input logic racc, input logic [7:0] qexp);
        we = w; d = dv; rd = r;
        @(posedge clk);
        #1;
        if (racc) sb.push_back('{qexp, cyc});
        we = 1'b0; rd = 1'b0;
    endtask

    task automatic chk_flags(input string nm, input int n, input logic f, input logic e,
                             input logic af, input logic ae);
        chk({nm, ".count"}, 32'(count), 32'(n));
        chk({nm, ".full"}, 32'(full), 32'(f));
        chk({nm, ".empty"}, 32'(empty), 32'(e));
        chk({nm, ".almost_full"}, 32'(almost_full), 32'(af));
        chk({nm, ".almost_empty"}, 32'(almost_empty), 32'(ae));
    endtask

    // Monitor: every q_valid must match the oldest outstanding read, on time.
    always @(negedge clk) begin
        if (q_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errs++;
                $display("FAIL q_unexpected: got q=0x%0h with q_valid, expected no data (cycle %0d)", q, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (q !== mon_e.data || cyc != mon_e.cyc) begin
                    errs++;
                    $display("FAIL q_data: got 0x%0h at cycle %0d, expected 0x%0h at cycle %0d",
                             q, cyc, mon_e.data, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; we = 1'b1; rd = 1'b1; d = 8'hFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; we = 1'b0; rd = 1'b0;
        chk_flags("reset", 0, 0, 1, 0, 1);
        chk("reset.q", 32'(q), 0);
        chk("reset.q_valid", 32'(q_valid), 0);

        // fill 0x11..0x88; almost_full from count 6
        for (int i = 0; i < 8; i++) begin
            step(1, 8'(8'h11 * (i + 1)), 0, 0, 0);
            chk_flags("fill", i + 1, (i == 7), 0, (i >= 5), (i <= 1));
        end

        // write attempt at full is rejected
        step(1, 8'hCC, 0, 0, 0);
        chk_flags("ovf_try", 8, 1, 0, 1, 0);
`ifdef SYNC_FIFO_ERR_EN
        chk("ovf_set", 32'(ovf), 1);
        chk("udf_clear", 32'(udf), 0);
`endif

        // drain in order
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 1, 8'(8'h11 * (i + 1)));
            chk("drain.count", 32'(count), 32'(7 - i));
        end
        chk_flags("drained", 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("idle.q_valid", 32'(q_valid), 0);
        chk("idle.q_hold", 32'(q), 32'h88);

        // read attempt at empty is rejected
        step(0, 0, 1, 0, 0);
        chk("udf_try.count", 32'(count), 0);
        chk("udf_try.q_valid", 32'(q_valid), 0);
        chk("udf_try.q_hold", 32'(q), 32'h88);
`ifdef SYNC_FIFO_ERR_EN
        chk("udf_set", 32'(udf), 1);
        chk("ovf_sticky", 32'(ovf), 1);
`endif

        // steady count 4 with simultaneous traffic across pointer wraps
        for (int i = 0; i < 4; i++) step(1, 8'(i + 1), 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 8'(8'h05 + i), 1, 1, 8'(8'h01 + i));
            chk("stream.count", 32'(count), 4);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 8'(8'h15 + i));
        chk_flags("stream_drained", 0, 0, 1, 0, 1);

        // full with we=rd=1: pop oldest, drop write
        for (int i = 0; i < 8; i++) step(1, 8'(8'h30 + i), 0, 0, 0);
        step(1, 8'hEE, 1, 1, 8'h30);
        chk_flags("full_wr_rd", 7, 0, 0, 1, 0);
        for (int i = 1; i < 8; i++) step(0, 0, 1, 1, 8'(8'h30 + i));
        chk("full_wr_rd.empty", 32'(empty), 1);

        // empty with we=rd=1: push only
        step(1, 8'h5A, 1, 0, 0);
        chk_flags("empty_wr_rd", 1, 0, 0, 0, 1);
        chk("empty_wr_rd.q_valid", 32'(q_valid), 0);
        step(0, 0, 1, 1, 8'h5A);
        chk("empty_wr_rd.after", 32'(count), 0);

        // reset mid-operation discards contents
        for (int i = 0; i < 5; i++) step(1, 8'(8'h61 + i), 0, 0, 0);
        chk("pre_rst.count", 32'(count), 5);
        rst = 1'b1;
        step(1, 8'h77, 1, 0, 0);
        rst = 1'b0;
        chk_flags("mid_rst", 0, 0, 1, 0, 1);
        chk("mid_rst.q", 32'(q), 0);
        chk("mid_rst.q_valid", 32'(q_valid), 0);
`ifdef SYNC_FIFO_ERR_EN
        chk("mid_rst.ovf", 32'(ovf), 0);
        chk("mid_rst.udf", 32'(udf), 0);
`endif
        step(1, 8'hA5, 0, 0, 0);
        step(0, 0, 1, 1, 8'hA5);
        chk("post_rst.count", 32'(count), 0);

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("scoreboard_drained", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-003 Parameter DEPTH, default 8, number of storage words (power of two, >=4).
REQ-004 Parameter AF_LEVEL, default DEPTH-2, almost_full threshold in words.
REQ-005 Parameter AE_LEVEL, default 2, almost_empty threshold in words.
REQ-006 Local AW = log2(DEPTH); not overridable.
REQ-007 clk  input  1  rising-edge clock for all state.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 we  input  1  write request.
REQ-010 d  input  WIDTH  write data.
REQ-011 rd  input  1  read request.
REQ-012 q  output  WIDTH  registered read data.
REQ-013 q_valid  output  1  q holds newly popped data this cycle.
REQ-014 full, empty  output  1 each  occupancy flags.
REQ-015 almost_full, almost_empty  output  1 each  threshold flags.
REQ-016 count  output  AW+1  words currently stored, 0..DEPTH.
REQ-017 ovf, udf  output  1 each  sticky error flags (present only with SYNC_FIFO_ERR_EN).

Function
REQ-018 Storage SHALL be a DEPTH x WIDTH array written and read only at the clk edge; no fall-through.
REQ-019 Write accepted iff we=1 and full=0 at the edge; d stored at write pointer, pointer +1 mod DEPTH.
REQ-020 Read accepted iff rd=1 and empty=0 at the edge; q loads word at read pointer, pointer +1 mod DEPTH.
REQ-021 Read latency SHALL be one cycle: q and q_valid=1 appear the cycle after the accepted read edge.
REQ-022 q SHALL hold its last value when no read is accepted; q_valid SHALL be 0 in that cycle.
REQ-023 count SHALL be +1 on accepted write only, -1 on accepted read only, unchanged on both or neither.
REQ-024 Flags SHALL be decoded from registered count: empty = (count==0), full = (count==DEPTH), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL).
REQ-025 Full with we=1 and rd=1: read accepted, write rejected; count becomes DEPTH-1.
REQ-026 Empty with we=1 and rd=1: write accepted, read rejected; count becomes 1, q_valid stays 0.
REQ-027 Non-full, non-empty with we=1 and rd=1: both accepted, count unchanged.
REQ-028 Pointers SHALL wrap DEPTH-1 -> 0 with no data corruption or flag glitch.
REQ-029 Rejected requests SHALL change no state except the error flags.

Reset
REQ-030 On rst=1 at an edge: pointers=0, count=0, q=0, q_valid=0, ovf=0, udf=0.
REQ-031 Resulting outputs: empty=1, almost_empty=1, full=0, almost_full=0.
REQ-032 Reset SHALL override simultaneous we/rd; memory contents SHALL NOT be cleared.
REQ-033 Reset mid-operation SHALL discard all stored words; a subsequent read SHALL return the first post-reset write.

Configuration
REQ-034 Macro SYNC_FIFO_ERR_EN defined: ovf set on write attempt while full, udf set on read attempt while empty; both sticky until rst.
REQ-035 Macro SYNC_FIFO_ERR_EN undefined: ovf and udf ports and logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=8, DEPTH=8, defaults)
REQ-036 Reset, then write 0x11..0x88 on 8 consecutive cycles -> count=8, full=1, almost_full=1 from count=6, empty=0.
REQ-037 From full, 8 consecutive reads -> q = 0x11..0x88 in order, each one cycle after its read edge, q_valid=1 each cycle, empty=1 after last.
REQ-038 Hold count=4, then 20 cycles of we=rd=1 with incrementing data -> count stays 4, output order preserved across two pointer wraps.
REQ-039 Full + we=rd=1 -> count=7, oldest word popped, write data not stored; empty + we=rd=1 -> count=1, q_valid=0.
REQ-040 With SYNC_FIFO_ERR_EN: write at full -> ovf=1, read at empty -> udf=1, both held until rst; without macro, same stimulus leaves count/data unchanged.
REQ-041 Write 5 words, assert rst with we=rd=1 -> count=0, empty=1, q=0; write 0xA5 then read -> q=0xA5.
